// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; updates from EX land on the next rising edge.
module riscv_core_branch_predictor #(
  parameter int ADDRLEN     = 32,
  parameter int NUM_ENTRIES = 16
) (
  input  logic               i_branch_predictor_clk,
  input  logic               i_branch_predictor_rst,
  input  logic [ADDRLEN-1:0] i_branch_predictor_fetch_PC,
  output logic               o_branch_predictor_valid,
  output logic               o_branch_predictor_isTaken,
  output logic [ADDRLEN-1:0] o_branch_predictor_predictedAddr,
  input  logic               i_branch_predictor_update_en,
  input  logic [ADDRLEN-1:0] i_branch_predictor_update_PC,
  input  logic [ADDRLEN-1:0] i_branch_predictor_update_target,
  input  logic               i_branch_predictor_update_taken,
  input  logic               i_branch_predictor_update_is_branch,
  input  logic               i_branch_predictor_flush
);

  localparam int IDXW = $clog2(NUM_ENTRIES);
  localparam int TAGW = ADDRLEN - IDXW - 1;

  logic               entry_valid  [NUM_ENTRIES];
  logic [TAGW-1:0]    entry_tag    [NUM_ENTRIES];
  logic [ADDRLEN-1:0] entry_target [NUM_ENTRIES];
  logic [1:0]         entry_cnt    [NUM_ENTRIES];

  // PC[0] never selects an entry: compressed instructions are 16-bit aligned.
  logic [IDXW-1:0] fetch_idx;
  logic [TAGW-1:0] fetch_tag;
  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            fetch_hit;
  logic            upd_hit;
  logic [1:0]      upd_cnt_next;

  assign fetch_idx = i_branch_predictor_fetch_PC[IDXW:1];
  assign fetch_tag = i_branch_predictor_fetch_PC[ADDRLEN-1:IDXW+1];
  assign upd_idx   = i_branch_predictor_update_PC[IDXW:1];
  assign upd_tag   = i_branch_predictor_update_PC[ADDRLEN-1:IDXW+1];

  assign fetch_hit = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);
  assign upd_hit   = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

  // Outputs are forced to zero on a miss so stale targets never reach next-PC.
  always_comb begin
    o_branch_predictor_valid         = 1'b0;
    o_branch_predictor_isTaken       = 1'b0;
    o_branch_predictor_predictedAddr = '0;
    if (fetch_hit) begin
      o_branch_predictor_valid         = 1'b1;
      o_branch_predictor_isTaken       = entry_cnt[fetch_idx][1];
      o_branch_predictor_predictedAddr = entry_target[fetch_idx];
    end
  end

  always_comb begin
    upd_cnt_next = entry_cnt[upd_idx];
    if (i_branch_predictor_update_taken) begin
      if (entry_cnt[upd_idx] != 2'b11) upd_cnt_next = entry_cnt[upd_idx] + 2'b01;
    end else begin
      if (entry_cnt[upd_idx] != 2'b00) upd_cnt_next = entry_cnt[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge i_branch_predictor_clk or posedge i_branch_predictor_rst) begin
    if (i_branch_predictor_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_cnt[i]    <= 2'b01;
      end
    end else if (i_branch_predictor_flush) begin
      // Only valid bits drop; history survives for when entries are re-allocated.
      for (int i = 0; i < NUM_ENTRIES; i++) entry_valid[i] <= 1'b0;
    end else if (i_branch_predictor_update_en) begin
      if (upd_hit) begin
        if (i_branch_predictor_update_is_branch) begin
          entry_cnt[upd_idx] <= upd_cnt_next;
          if (i_branch_predictor_update_taken)
            entry_target[upd_idx] <= i_branch_predictor_update_target;
        end else begin
          entry_cnt[upd_idx]    <= 2'b11;
          entry_target[upd_idx] <= i_branch_predictor_update_target;
        end
      end else if (i_branch_predictor_update_taken) begin
        entry_valid[upd_idx]  <= 1'b1;
        entry_tag[upd_idx]    <= upd_tag;
        entry_target[upd_idx] <= i_branch_predictor_update_target;
        entry_cnt[upd_idx]    <= i_branch_predictor_update_is_branch ? 2'b10 : 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Bench for the branch predictor: directed vector table, reset corner cases,
// then random traffic against an index/tag arithmetic model.
module tb_riscv_core_branch_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        bp_valid;
  logic        bp_taken;
  logic [31:0] bp_addr;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_tgt;
  logic        upd_taken;
  logic        upd_is_br;
  logic        flush;

  int checks = 0;
  int errors = 0;

  riscv_core_branch_predictor #(.ADDRLEN(32), .NUM_ENTRIES(N)) dut (
    .i_branch_predictor_clk             (clk),
    .i_branch_predictor_rst             (rst),
    .i_branch_predictor_fetch_PC        (fetch_pc),
    .o_branch_predictor_valid           (bp_valid),
    .o_branch_predictor_isTaken         (bp_taken),
    .o_branch_predictor_predictedAddr   (bp_addr),
    .i_branch_predictor_update_en       (upd_en),
    .i_branch_predictor_update_PC       (upd_pc),
    .i_branch_predictor_update_target   (upd_tgt),
    .i_branch_predictor_update_taken    (upd_taken),
    .i_branch_predictor_update_is_branch(upd_is_br),
    .i_branch_predictor_flush           (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        is_br;
    logic        fl;
    logic [31:0] fetch;
    logic        ev;
    logic        et;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs [20];

  // Reference model: entry chosen by halfword address modulo depth, tag is the rest.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_cnt   [N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int unsigned i = (pc / 2) % N;
    return m_valid[i] && (m_tag[i] == pc / (2 * N));
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic v,
                                       output logic t, output logic [31:0] a);
    int unsigned i = (pc / 2) % N;
    v = model_hit(pc);
    t = v && (m_cnt[i] >= 2);
    a = v ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void model_update(input logic en, input logic [31:0] pc,
                                       input logic [31:0] tgt, input logic tk,
                                       input logic br, input logic fl);
    int unsigned i = (pc / 2) % N;
    if (fl) begin
      for (int k = 0; k < N; k++) m_valid[k] = 0;
    end else if (en) begin
      if (model_hit(pc)) begin
        if (br) begin
          m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                        : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
          if (tk) m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = 3; m_tgt[i] = tgt;
        end
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = pc / (2 * N); m_tgt[i] = tgt;
        m_cnt[i] = br ? 2 : 3;
      end
    end
  endfunction

  task automatic check_out(input string name, input logic ev, input logic et,
                           input logic [31:0] ea);
    checks++;
    if (bp_valid !== ev || bp_taken !== et || bp_addr !== ea) begin
      errors++;
      $display("FAIL %s: fetch=%h got valid=%b taken=%b addr=%h, want valid=%b taken=%b addr=%h",
               name, fetch_pc, bp_valid, bp_taken, bp_addr, ev, et, ea);
    end
  endtask

  task automatic idle_inputs();
    upd_en = 0; upd_pc = 0; upd_tgt = 0; upd_taken = 0; upd_is_br = 0; flush = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1);
    if ($urandom_range(0, 7) == 0) p = p | 32'h8000_0000;
    return p;
  endfunction

  initial begin
    //          upd pc        tgt           tk br fl fetch        ev et ea
    vecs[0]  = '{1, 32'h100, 32'h200, 1, 1, 0, 32'h100, 0, 0, 32'h0};
    vecs[1]  = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h100, 1, 1, 32'h200};
    vecs[2]  = '{1, 32'h100, 32'h999, 0, 1, 0, 32'h100, 1, 1, 32'h200};
    vecs[3]  = '{1, 32'h100, 32'h999, 0, 1, 0, 32'h100, 1, 0, 32'h200};
    vecs[4]  = '{1, 32'h100, 32'h200, 1, 1, 0, 32'h100, 1, 0, 32'h200};
    vecs[5]  = '{1, 32'h100, 32'h280, 1, 1, 0, 32'h100, 1, 0, 32'h200};
    vecs[6]  = '{1, 32'h100, 32'h280, 1, 1, 0, 32'h100, 1, 1, 32'h280};
    vecs[7]  = '{1, 32'h100, 32'h280, 1, 1, 0, 32'h100, 1, 1, 32'h280};
    vecs[8]  = '{1, 32'h144, 32'h500, 0, 1, 0, 32'h100, 1, 1, 32'h280};
    vecs[9]  = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h144, 0, 0, 32'h0};
    vecs[10] = '{1, 32'h120, 32'h300, 1, 1, 0, 32'h120, 0, 0, 32'h0};
    vecs[11] = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h100, 0, 0, 32'h0};
    vecs[12] = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h120, 1, 1, 32'h300};
    vecs[13] = '{1, 32'h120, 32'h300, 0, 1, 0, 32'h120, 1, 1, 32'h300};
    vecs[14] = '{1, 32'h104, 32'h400, 1, 0, 0, 32'h120, 1, 0, 32'h300};
    vecs[15] = '{1, 32'h120, 32'h380, 1, 0, 0, 32'h104, 1, 1, 32'h400};
    vecs[16] = '{1, 32'h108, 32'h600, 1, 0, 1, 32'h120, 1, 1, 32'h380};
    vecs[17] = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h104, 0, 0, 32'h0};
    vecs[18] = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h120, 0, 0, 32'h0};
    vecs[19] = '{0, 32'h0,   32'h0,   0, 0, 0, 32'h108, 0, 0, 32'h0};

    idle_inputs();
    rst = 1'b1;
    fetch_pc = 32'h100;
    #3;
    check_out("reset_lookup", 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_out("post_reset_lookup", 0, 0, 32'h0);

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      upd_en = vecs[v].upd; upd_pc = vecs[v].pc; upd_tgt = vecs[v].tgt;
      upd_taken = vecs[v].taken; upd_is_br = vecs[v].is_br; flush = vecs[v].fl;
      fetch_pc = vecs[v].fetch;
      #1 check_out($sformatf("vec%0d", v), vecs[v].ev, vecs[v].et, vecs[v].ea);
    end

    // Asynchronous reset between edges after populating two entries.
    @(negedge clk);
    idle_inputs();
    upd_en = 1; upd_pc = 32'h100; upd_tgt = 32'h200; upd_taken = 1; upd_is_br = 1;
    @(negedge clk);
    upd_pc = 32'h104; upd_tgt = 32'h400; upd_is_br = 0;
    @(negedge clk);
    idle_inputs();
    fetch_pc = 32'h104;
    #1 check_out("populated_104", 1, 1, 32'h400);
    fetch_pc = 32'h100;
    #1 check_out("populated_100", 1, 1, 32'h200);
    rst = 1'b1;
    #1 check_out("async_rst_100", 0, 0, 32'h0);
    fetch_pc = 32'h104;
    #1 check_out("async_rst_104", 0, 0, 32'h0);
    @(negedge clk);
    upd_en = 1; upd_pc = 32'h104; upd_tgt = 32'h700; upd_taken = 1; upd_is_br = 0;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1 check_out("after_rst_104", 0, 0, 32'h0);
    fetch_pc = 32'h100;
    #1 check_out("after_rst_100", 0, 0, 32'h0);
    model_reset();

    for (int c = 0; c < 600; c++) begin
      logic ev, et;
      logic [31:0] ea;
      @(negedge clk);
      upd_en    = ($urandom_range(0, 1) == 1);
      upd_pc    = rand_pc();
      upd_tgt   = $urandom & 32'hFFFF_FFFE;
      upd_taken = ($urandom_range(0, 9) < 6);
      upd_is_br = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      fetch_pc  = ($urandom_range(0, 3) == 0) ? upd_pc : rand_pc();
      #1;
      model_lookup(fetch_pc, ev, et, ea);
      check_out($sformatf("rand%0d", c), ev, et, ea);
      @(posedge clk);
      model_update(upd_en, upd_pc, upd_tgt, upd_taken, upd_is_br, flush);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_branch_predictor.md
RISCV_CORE_BRANCH_PREDICTOR -- requirements
Module: riscv_core_branch_predictor

Interface
REQ-001 SHALL have parameter ADDRLEN, default 32, meaning PC/target width.
REQ-002 SHALL have parameter NUM_ENTRIES, default 16, meaning BTB depth; power of 2, >= 2; IDXW = log2(NUM_ENTRIES).
REQ-003 i_branch_predictor_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_branch_predictor_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_branch_predictor_fetch_PC  input  ADDRLEN  PC being fetched (lookup key).
REQ-006 o_branch_predictor_valid  output  1  lookup hit; feeds next-PC valid.
REQ-007 o_branch_predictor_isTaken  output  1  predicted direction; feeds next-PC isTaken_BP.
REQ-008 o_branch_predictor_predictedAddr  output  ADDRLEN  predicted target; feeds next-PC predictedAddr.
REQ-009 i_branch_predictor_update_en  input  1  resolved control-flow instruction from EX this cycle.
REQ-010 i_branch_predictor_update_PC  input  ADDRLEN  PC of the resolved instruction.
REQ-011 i_branch_predictor_update_target  input  ADDRLEN  resolved target address.
REQ-012 i_branch_predictor_update_taken  input  1  resolved direction.
REQ-013 i_branch_predictor_update_is_branch  input  1  1 = conditional branch, 0 = JAL/JALR.
REQ-014 i_branch_predictor_flush  input  1  invalidate all entries (e.g. FENCE.I).

Function
REQ-015 Storage per entry: valid bit, tag PC[ADDRLEN-1:IDXW+1], target ADDRLEN, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 Index = PC[IDXW:1]; PC[0] ignored (16-bit alignment, C extension).
REQ-017 Lookup is combinational, zero latency: hit = valid[idx] AND tag[idx] == fetch tag.
REQ-018 On hit: valid=1, isTaken=counter[1], predictedAddr=target[idx].
REQ-019 On miss: valid=0, isTaken=0, predictedAddr=0 (forced, never stale data).
REQ-020 Update, hit on update_PC, is_branch=1: counter saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00); target overwritten only when taken.
REQ-021 Update, hit, is_branch=0: counter := 11, target := update_target.
REQ-022 Update, miss, taken=1: allocate (overwrite any aliased entry): valid=1, tag, target; counter := 10 if is_branch, 11 if jump.
REQ-023 Update, miss, taken=0: no state change.
REQ-024 Update writes take effect at the next rising edge; same-cycle lookup of the same index returns pre-update contents (no bypass).
REQ-025 flush=1: all valid bits cleared at next edge; counters, tags, targets retained; flush wins over a same-cycle update.
REQ-026 No internal stall: upstream holds fetch_PC stable when frozen; update_en asserted at most once per resolved instruction.

Reset
REQ-027 Assertion of rst SHALL immediately (asynchronously) clear all valid bits, set all counters to 01, tags and targets to 0.
REQ-028 During and after reset, outputs SHALL be valid=0, isTaken=0, predictedAddr=0 until an allocating update.
REQ-029 Reset asserted mid-update SHALL discard that update; deassertion is synchronised externally to the clock.

Verification (NUM_ENTRIES=16, ADDRLEN=32)
REQ-030 After reset, fetch_PC=0x100 -> valid=0, isTaken=0, predictedAddr=0x0.
REQ-031 Update PC=0x100, target=0x200, taken=1, is_branch=1; next cycle fetch 0x100 -> valid=1, isTaken=1, addr=0x200 (counter 10); same-cycle lookup during update -> valid=0.
REQ-032 From REQ-031 state: 2 not-taken updates -> counter 00, valid=1, isTaken=0; then 4 taken updates -> 01,10,11,11 (saturation), isTaken=1.
REQ-033 Alias: 0x100 allocated, then update PC=0x120 (same idx 0, other tag), taken, target=0x300 -> fetch 0x100 valid=0; fetch 0x120 valid=1, addr=0x300.
REQ-034 JAL update PC=0x104, target=0x400, is_branch=0, taken=1 -> counter 11; same cycle as flush=1 -> next cycle all lookups valid=0.
REQ-035 Populate 0x100 and 0x104, assert rst asynchronously between clock edges -> outputs go to 0 before next edge; after release, all lookups miss.
